// File: rtl/bcd_operand_loader_pkg.sv
// Shared types and constants for the BCD operand loader: FSM state encoding,
// the largest legal BCD digit, and the shift amounts used for the x10 multiply.
package bcd_loader_pkg;

    typedef enum logic [2:0] {
        A_TENS  = 3'd0,
        A_UNITS = 3'd1,
        B_TENS  = 3'd2,
        B_UNITS = 3'd3,
        HOLD    = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // x*10 is computed as (x<<3) + (x<<1)
    localparam int X10_SHL_HI = 3;
    localparam int X10_SHL_LO = 1;

endpackage

// File: rtl/bcd2bin_2dig.sv
// Two BCD digits to a binary value (tens*10 + units).
// When neg is set the result is the two's complement of that value.
import bcd_loader_pkg::*;

module bcd2bin_2dig #(
    parameter int OP_W = 8
) (
    input  logic [3:0]      tens,
    input  logic [3:0]      units,
    input  logic            neg,
    output logic [OP_W-1:0] result
);

    logic [OP_W-1:0] t_ext;
    logic [OP_W-1:0] u_ext;
    logic [OP_W-1:0] mag;

    assign t_ext  = OP_W'(tens);
    assign u_ext  = OP_W'(units);
    assign mag    = (t_ext << X10_SHL_HI) + (t_ext << X10_SHL_LO) + u_ext;
    assign result = neg ? (~mag + OP_W'(1)) : mag;

endmodule

// File: rtl/bcd_operand_loader.sv
// Collects four keypad BCD digits into two operands for the Booth multiplier.
// Define BCD_LOADER_SIGN_EN to enable the minus key (signed operands -99..99).
//
// state   | meaning
// A_TENS  | waiting for tens digit of op_a
// A_UNITS | waiting for units digit of op_a
// B_TENS  | waiting for tens digit of op_b
// B_UNITS | waiting for units digit of op_b
// HOLD    | pair valid, waiting for op_ready
import bcd_loader_pkg::*;

module bcd_operand_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int OP_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      digit_in,
    input  logic            key_strobe,
    input  logic            sign_key,
    input  logic            clr,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic            op_valid,
    input  logic            op_ready,
    output logic            entry_err
);

    state_e                 state;
    logic [3:0]             tens_a;
    logic [3:0]             tens_b;
    logic                   neg_a;
    logic                   neg_b;
    logic [OP_W-1:0]        conv_a;
    logic [OP_W-1:0]        conv_b;

    logic [SYNC_STAGES-1:0] key_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   key_d;
    logic                   key_armed;
    logic                   digit_ev;
    logic                   sign_ev;
    logic                   digit_ok;
    logic                   xfer;

    // fill marks when the synchronizer holds real samples, so a strobe held
    // across reset release must be seen low before it can arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_sync  <= '0;
            fill      <= '0;
            key_d     <= 1'b0;
            key_armed <= 1'b0;
        end else begin
            key_sync <= {key_sync[SYNC_STAGES-2:0], key_strobe};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            key_d    <= key_sync[SYNC_STAGES-1];
            if (fill[SYNC_STAGES-1] && !key_sync[SYNC_STAGES-1])
                key_armed <= 1'b1;
        end
    end

    assign digit_ev = key_sync[SYNC_STAGES-1] & ~key_d & key_armed;

`ifdef BCD_LOADER_SIGN_EN
    logic [SYNC_STAGES-1:0] sign_sync;
    logic                   sign_d;
    logic                   sign_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_sync  <= '0;
            sign_d     <= 1'b0;
            sign_armed <= 1'b0;
        end else begin
            sign_sync <= {sign_sync[SYNC_STAGES-2:0], sign_key};
            sign_d    <= sign_sync[SYNC_STAGES-1];
            if (fill[SYNC_STAGES-1] && !sign_sync[SYNC_STAGES-1])
                sign_armed <= 1'b1;
        end
    end

    assign sign_ev = sign_sync[SYNC_STAGES-1] & ~sign_d & sign_armed;
`else
    logic unused_sign;
    assign unused_sign = sign_key;
    assign sign_ev     = 1'b0;
`endif

    assign digit_ok = (digit_in <= BCD_MAX);
    assign xfer     = op_valid & op_ready;

    bcd2bin_2dig #(.OP_W(OP_W)) u_conv_a (
        .tens   (tens_a),
        .units  (digit_in),
        .neg    (neg_a),
        .result (conv_a)
    );

    bcd2bin_2dig #(.OP_W(OP_W)) u_conv_b (
        .tens   (tens_b),
        .units  (digit_in),
        .neg    (neg_b),
        .result (conv_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= A_TENS;
            tens_a    <= 4'd0;
            tens_b    <= 4'd0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            if (clr) begin
                state    <= A_TENS;
                tens_a   <= 4'd0;
                tens_b   <= 4'd0;
                neg_a    <= 1'b0;
                neg_b    <= 1'b0;
                op_valid <= 1'b0;
            end else if (xfer) begin
                // a digit arriving with the transfer is dropped silently
                state    <= A_TENS;
                neg_a    <= 1'b0;
                neg_b    <= 1'b0;
                op_valid <= 1'b0;
            end else begin
                if (sign_ev && state == A_TENS) neg_a <= ~neg_a;
                if (sign_ev && state == B_TENS) neg_b <= ~neg_b;
                if (digit_ev) begin
                    if (state == HOLD || !digit_ok) begin
                        entry_err <= 1'b1;
                    end else begin
                        case (state)
                            A_TENS: begin
                                tens_a <= digit_in;
                                state  <= A_UNITS;
                            end
                            A_UNITS: begin
                                op_a  <= conv_a;
                                state <= B_TENS;
                            end
                            B_TENS: begin
                                tens_b <= digit_in;
                                state  <= B_UNITS;
                            end
                            B_UNITS: begin
                                op_b     <= conv_b;
                                op_valid <= 1'b1;
                                state    <= HOLD;
                            end
                            default: state <= A_TENS;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed testbench for bcd_operand_loader; hand-computed expectations.
// Build with BCD_LOADER_SIGN_EN defined to also exercise the minus key.
module tb_bcd_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       key_strobe = 1'b0;
    logic       sign_key = 1'b0;
    logic       clr = 1'b0;
    logic       op_ready = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_valid;
    logic       entry_err;

    int n_checks = 0;
    int n_errors = 0;
    int valid_tot = 0;
    int err_tot = 0;
    int base_v;
    int base_e;

    bcd_operand_loader #(.SYNC_STAGES(2), .OP_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_in   (digit_in),
        .key_strobe (key_strobe),
        .sign_key   (sign_key),
        .clr        (clr),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .entry_err  (entry_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_valid)  valid_tot++;
        if (entry_err) err_tot++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        digit_in = d;
        @(negedge clk);
        key_strobe = 1'b1;
        repeat (4) @(negedge clk);
        key_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // strobe held high through reset must not count as a digit
        digit_in   = 4'd5;
        key_strobe = 1'b1;
        #12;
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_valid", op_valid, 0);
        check("rst_err", entry_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(10);
        key_strobe = 1'b0;
        cycles(4);
        op_ready = 1'b0;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("held_strobe_op_a", op_a, 12);
        check("held_strobe_op_b", op_b, 34);
        check("held_strobe_valid", op_valid, 1);
        op_ready = 1'b1;
        cycles(2);
        check("held_strobe_xfer", op_valid, 0);

        // reset mid-entry
        press(4'd6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_op_a", op_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        press(4'd7); press(4'd8); press(4'd1); press(4'd2);
        check("mid_rst_next_op_a", op_a, 78);

        // 4,7,1,2 with op_ready high: single-cycle valid
        base_v = valid_tot; base_e = err_tot;
        press(4'd4); press(4'd7); press(4'd1); press(4'd2);
        check("t1_op_a", op_a, 47);
        check("t1_op_b", op_b, 12);
        check("t1_valid_cycles", valid_tot - base_v, 1);
        check("t1_no_err", err_tot - base_e, 0);

        // 9,9,9,9 held for 5 cycles
        op_ready = 1'b0;
        press(4'd9); press(4'd9); press(4'd9); press(4'd9);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", op_valid, 1);
            check("t2_hold_op_a", op_a, 99);
            check("t2_hold_op_b", op_b, 99);
            @(negedge clk);
        end
        op_ready = 1'b1;
        @(negedge clk);
        check("t2_xfer_valid", op_valid, 0);
        check("t2_after_op_a", op_a, 99);

        // invalid digit 0xC dropped with error pulse
        base_e = err_tot;
        press(4'd3);
        press(4'hC);
        check("t3_err_pulse", err_tot - base_e, 1);
        press(4'd5);
        check("t3_op_a", op_a, 35);
        press(4'd0); press(4'd0);
        check("t3_op_b", op_b, 0);

        // clr aborts partial entry
        press(4'd1); press(4'd2);
        @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0;
        press(4'd0); press(4'd8); press(4'd0); press(4'd6);
        check("t4_op_a", op_a, 8);
        check("t4_op_b", op_b, 6);

        // digit during HOLD
        op_ready = 1'b0;
        press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        base_e = err_tot;
        press(4'd7);
        check("t5_hold_err", err_tot - base_e, 1);
        check("t5_op_a", op_a, 23);
        check("t5_op_b", op_b, 45);
        check("t5_valid", op_valid, 1);

        // clr during HOLD discards the pair
        @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("t6_clr_valid", op_valid, 0);
        op_ready = 1'b1;
        base_v = valid_tot;
        press(4'd5); press(4'd5); press(4'd6); press(4'd6);
        check("t6_valid_cycles", valid_tot - base_v, 1);
        check("t6_op_a", op_a, 55);
        check("t6_op_b", op_b, 66);

`ifdef BCD_LOADER_SIGN_EN
        @(negedge clk); sign_key = 1'b1;
        cycles(4);
        sign_key = 1'b0;
        cycles(4);
        press(4'd2); press(4'd5); press(4'd0); press(4'd3);
        check("sign_op_a", op_a, 8'hE7);
        check("sign_op_b", op_b, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
